// File: rtl/sprite_blitter.sv
// Sprite ROM reader: walks the sprite in raster order and turns every
// opaque, on-screen pixel into a frame-buffer write (we/ready handshake).
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   start               blit request, taken only when idle
//   sprite_x, sprite_y  screen position of the sprite's top-left pixel
//   busy, done          busy outside IDLE; done pulses once at the end
//   rom_addr, rom_data  sprite ROM read port (combinational ROM)
//   fb_we, fb_addr,     frame-buffer write request, held until the
//   fb_data, fb_ready   buffer accepts it on an edge with fb_ready=1
module sprite_blitter #(
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 51,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [2:0] TRANSPARENT = 3'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic        busy,
  output logic        done,
  output logic [18:0] rom_addr,
  input  logic [2:0]  rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [2:0]  fb_data,
  input  logic        fb_ready
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t       state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [9:0]   x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic [18:0]  rom_addr_q, rom_addr_d;
  logic         we_q, we_d;
  logic [18:0]  fba_q, fba_d;
  logic [2:0]   fbd_q, fbd_d;

  // Screen coordinates carry one extra bit so x+col never wraps.
  logic [10:0]   sx, sy;
  logic          on_screen;
  logic          last_px;
  logic          adv;
  logic          row_end;
  logic [CW-1:0] col_adv;
  logic [RW-1:0] row_adv;
  logic [18:0]   px_addr;

  assign sx = {1'b0, x_q} + 11'(col_q);
  assign sy = {1'b0, y_q} + 11'(row_q);

  assign on_screen = (sx < 11'(SCREEN_W))
                   && (sy < 11'(SCREEN_H));

  assign row_end = (col_q == CW'(SPR_W - 1));
  assign last_px = row_end
                 && (row_q == RW'(SPR_H - 1));

  assign col_adv = row_end ? '0 : col_q + 1'b1;
  assign row_adv = row_end ? row_q + 1'b1 : row_q;

  assign px_addr = 19'(sy) * 19'(SCREEN_W)
                 + 19'(sx);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    x_d        = x_q;
    y_d        = y_q;
    rom_addr_d = rom_addr_q;
    we_d       = we_q;
    fba_d      = fba_q;
    fbd_d      = fbd_q;
    adv        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d        = sprite_x;
          y_d        = sprite_y;
          col_d      = '0;
          row_d      = '0;
          rom_addr_d = '0;
          state_d    = READ;
        end
      end
      READ: begin
        if (rom_data == TRANSPARENT || !on_screen) begin
          adv = 1'b1;
        end else begin
          fbd_d   = rom_data;
          fba_d   = px_addr;
          we_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (fb_ready) begin
          we_d = 1'b0;
          adv  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (adv) begin
      if (last_px) begin
        state_d = DONE;
      end else begin
        col_d      = col_adv;
        row_d      = row_adv;
        rom_addr_d = 19'(row_adv) * 19'(SPR_W)
                   + 19'(col_adv);
        state_d    = READ;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rom_addr_q <= '0;
      we_q       <= 1'b0;
      fba_q      <= '0;
      fbd_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rom_addr_q <= rom_addr_d;
      we_q       <= we_d;
      fba_q      <= fba_d;
      fbd_q      <= fbd_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rom_addr = rom_addr_q;
  assign fb_we    = we_q;
  assign fb_addr  = fba_q;
  assign fb_data  = fbd_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: ROM image in an array, expected
// write list computed from the blit rules, compared to observed writes.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        busy;
  logic        done;
  logic [18:0] rom_addr;
  logic [2:0]  rom_data;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_ready;

  sprite_blitter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_ready (fb_ready)
  );

  always #5 Clk = ~Clk;

  logic [2:0] rom_mem [0:1631];

  assign rom_data = (rom_addr < 19'd1632)
                  ? rom_mem[rom_addr[10:0]] : 3'd0;

  int n_chk = 0;
  int n_err = 0;

  int exp_a[$];
  int exp_d[$];
  int obs_a[$];
  int obs_d[$];

  int cyc;
  int first_we;
  int held;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic fill_rom(input int mode);
    for (int i = 0; i < 1632; i++) begin
      case (mode)
        0: rom_mem[i] = 3'((i % 7) + 1);
        1: rom_mem[i] = 3'd0;
        default:
          rom_mem[i] = ($urandom_range(99) < 30)
                     ? 3'd0 : 3'($urandom_range(7, 1));
      endcase
    end
  endtask

  task automatic build_model(input int x, input int y);
    int d;
    exp_a.delete();
    exp_d.delete();
    for (int r = 0; r < 51; r++) begin
      for (int c = 0; c < 32; c++) begin
        d = int'(rom_mem[r * 32 + c]);
        if (d != 0 && x + c < 640 && y + r < 480) begin
          exp_a.push_back((y + r) * 640 + x + c);
          exp_d.push_back(d);
        end
      end
    end
  endtask

  task automatic compare_sb(input string tag);
    int n;
    check({tag, "_count"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size())
      ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, obs_a[i], exp_a[i]);
      check({tag, "_data"}, obs_d[i], exp_d[i]);
    end
  endtask

  task automatic blit(input int x, input int y,
                      input int rdy_pct, input int stall,
                      input bit disturb);
    int stall_left;
    bit post;
    logic [18:0] ha;
    logic [2:0]  hd;
    logic [18:0] hr;
    stall_left = stall;
    post = 1'b0;
    ha = '0;
    hd = '0;
    hr = '0;
    obs_a.delete();
    obs_d.delete();
    first_we = -1;
    held = 0;
    @(negedge Clk);
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    start = 1'b1;
    fb_ready = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20000) begin
      if (disturb && cyc == 10) begin
        start = 1'b1;
        sprite_x = 10'($urandom);
        sprite_y = 10'($urandom);
      end else begin
        start = 1'b0;
      end
      if (post) begin
        check("rom_addr_after_accept", rom_addr, 1);
        post = 1'b0;
      end
      if (fb_we && first_we < 0) begin
        first_we = cyc;
        ha = fb_addr;
        hd = fb_data;
        hr = rom_addr;
      end
      if (fb_we && stall_left > 0) begin
        fb_ready = 1'b0;
        stall_left--;
      end else begin
        fb_ready = ($urandom_range(99) < rdy_pct);
      end
      if (stall > 0 && fb_we && obs_a.size() == 0) begin
        held++;
        check("hold_addr", fb_addr, ha);
        check("hold_data", fb_data, hd);
        check("hold_rom_addr", rom_addr, hr);
      end
      if (fb_we && fb_ready) begin
        obs_a.push_back(int'(fb_addr));
        obs_d.push_back(int'(fb_data));
        if (stall > 0 && obs_a.size() == 1)
          post = 1'b1;
      end
      @(negedge Clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    @(negedge Clk);
    check("busy_fall", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fb_we"}, fb_we, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_fb_data"}, fb_data, 0);
  endtask

  int mx;
  int rx;
  int ry;

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    sprite_x = '0;
    sprite_y = '0;
    fb_ready = 1'b1;
    fill_rom(0);
    repeat (2) @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b0;

    // reset in the middle of a stalled write
    @(negedge Clk);
    start = 1'b1;
    fb_ready = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !fb_we; i++)
      @(negedge Clk);
    check("pre_reset_we", fb_we, 1);
    #2 Reset = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge Clk);
    Reset = 1'b0;
    fb_ready = 1'b1;

    // all opaque at the origin
    fill_rom(0);
    build_model(0, 0);
    blit(0, 0, 100, 0, 1'b0);
    check("a_writes", obs_a.size(), 1632);
    check("a_first_addr", obs_a.size() > 0 ? obs_a[0] : -1, 0);
    check("a_first_data", obs_d.size() > 0 ? obs_d[0] : -1, 1);
    check("a_last_addr",
          obs_a.size() > 0 ? obs_a[obs_a.size() - 1] : -1, 32031);
    check("a_first_we_cycle", first_we, 2);
    check("a_done_cycle", cyc, 3265);
    check("a_done_model", cyc, 1632 + exp_a.size() + 1);
    compare_sb("a");

    // all transparent
    fill_rom(1);
    build_model(0, 0);
    blit(0, 0, 100, 0, 1'b0);
    check("b_writes", obs_a.size(), 0);
    check("b_done_cycle", cyc, 1633);

    // clipped at the bottom-right corner
    fill_rom(0);
    build_model(620, 470);
    blit(620, 470, 100, 0, 1'b0);
    check("c_writes", obs_a.size(), 200);
    mx = -1;
    foreach (obs_a[i])
      if (obs_a[i] > mx) mx = obs_a[i];
    check("c_max_addr", mx, 307199);
    check("c_done_model", cyc, 1632 + exp_a.size() + 1);
    compare_sb("c");

    // first write stalled for 5 cycles
    fill_rom(0);
    build_model(0, 0);
    blit(0, 0, 100, 5, 1'b0);
    check("d_first_we_cycle", first_we, 2);
    check("d_held_cycles", held, 6);
    compare_sb("d");

    // random ROM, position and ready, with mid-blit disturbance
    for (int it = 0; it < 4; it++) begin
      fill_rom(2);
      if (it[0]) begin
        rx = $urandom_range(639, 580);
        ry = $urandom_range(479, 420);
      end else begin
        rx = $urandom_range(700, 0);
        ry = $urandom_range(500, 0);
      end
      build_model(rx, ry);
      blit(rx, ry, 70, 0, 1'b1);
      compare_sb("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
